// File: rtl/mips_multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: states, opcodes, functs and ALU ops.
package mips_multicycle_ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'd0,
        ALUOP_SUB   = 2'd1,
        ALUOP_FUNCT = 2'd2
    } aluop_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Instruction and data memory req/ack handshakes between the controller and the memory wrappers.
interface mips_multicycle_ctrl_if;
    logic        imem_req;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ack;

    modport master (output imem_req, dmem_req, dmem_we,
                    input  imem_ack, imem_rdata, dmem_ack);
    modport slave  (input  imem_req, dmem_req, dmem_we,
                    output imem_ack, imem_rdata, dmem_ack);
endinterface

// File: rtl/mips_multicycle_ctrl_alu_decoder.sv
// Maps the ALU operation class and R-type funct onto the datapath ALU control code.
module mips_multicycle_ctrl_alu_decoder
    import mips_multicycle_ctrl_pkg::*;
(
    input  logic [5:0] funct,
    input  aluop_e     aluop,
    output logic [2:0] alu_ctrl,
    output logic       illegal
);

    always_comb begin
        alu_ctrl = ALU_ADD;
        illegal  = 1'b0;
        case (aluop)
            ALUOP_ADD: alu_ctrl = ALU_ADD;
            ALUOP_SUB: alu_ctrl = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD:  alu_ctrl = ALU_ADD;
                    FN_SUB:  alu_ctrl = ALU_SUB;
                    FN_AND:  alu_ctrl = ALU_AND;
                    FN_OR:   alu_ctrl = ALU_OR;
                    FN_SLT:  alu_ctrl = ALU_SLT;
                    default: illegal  = 1'b1;
                endcase
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS sequencer: fetches over imem req/ack, then steps the datapath selects
// through DECODE/EXEC/MEM/WB with a shared wait-cycle timeout on both memory handshakes.
module mips_multicycle_ctrl
    import mips_multicycle_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int TW          = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   run,
    mips_multicycle_ctrl_if.master mem,
    output logic [31:0]            instruction,
    input  logic                   zero,
    output logic                   sel_result,
    output logic                   sel_pc,
    output logic                   sel_alu_b,
    output logic                   sel_wa,
    output logic                   we,
    output logic                   sel_jump,
    output logic [2:0]             alu_ctrl,
    output logic                   pc_en,
    output logic                   retire,
    output logic                   fault,
    output logic [2:0]             state
);

    localparam bit            TO_EN   = (MEM_TIMEOUT != 0);
    localparam logic [TW-1:0] TO_LAST = TW'(MEM_TIMEOUT - 1);

    state_e        state_q, state_d;
    logic [31:0]   instr_q, instr_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic          fault_q, fault_d;
    logic          issued_q, issued_d;

    logic       c_imem_req, c_dmem_req, c_dmem_we;
    logic       c_sel_result, c_sel_pc, c_sel_alu_b, c_sel_wa, c_we, c_sel_jump, c_pc_en;
    logic [2:0] c_alu_ctrl;

    logic [5:0] opcode;
    logic       is_r, is_j, is_addi, is_lw, is_sw, is_beq, op_legal;
    aluop_e     aluop;
    logic [2:0] dec_alu;
    logic       funct_bad;
    logic       timed_out;

    assign opcode   = instr_q[31:26];
    assign is_r     = (opcode == OP_RTYPE);
    assign is_j     = (opcode == OP_J);
    assign is_addi  = (opcode == OP_ADDI);
    assign is_lw    = (opcode == OP_LW);
    assign is_sw    = (opcode == OP_SW);
    assign is_beq   = (opcode == OP_BEQ);
    assign op_legal = is_r | is_j | is_addi | is_lw | is_sw | is_beq;
    assign aluop    = is_r ? ALUOP_FUNCT : (is_beq ? ALUOP_SUB : ALUOP_ADD);

    // Only meaningful on a waiting cycle; the counter holds the number of waits already seen.
    assign timed_out = TO_EN && (cnt_q == TO_LAST);

    mips_multicycle_ctrl_alu_decoder u_alu_dec (
        .funct    (instr_q[5:0]),
        .aluop    (aluop),
        .alu_ctrl (dec_alu),
        .illegal  (funct_bad)
    );

    always_comb begin
        state_d      = state_q;
        instr_d      = instr_q;
        cnt_d        = '0;
        fault_d      = fault_q;
        issued_d     = issued_q;
        c_imem_req   = 1'b0;
        c_dmem_req   = 1'b0;
        c_dmem_we    = 1'b0;
        c_sel_result = 1'b0;
        c_sel_pc     = 1'b0;
        c_sel_alu_b  = 1'b0;
        c_sel_wa     = 1'b0;
        c_we         = 1'b0;
        c_sel_jump   = 1'b0;
        c_pc_en      = 1'b0;
        c_alu_ctrl   = 3'b000;
        case (state_q)
            S_FETCH: begin
                // Once a request is out it is held regardless of run until ack.
                c_imem_req = run | issued_q;
                if (c_imem_req) begin
                    if (mem.imem_ack) begin
                        instr_d  = mem.imem_rdata;
                        issued_d = 1'b0;
                        state_d  = S_DECODE;
                    end else if (timed_out) begin
                        issued_d = 1'b0;
                        fault_d  = 1'b1;
                        state_d  = S_HALT;
                    end else begin
                        issued_d = 1'b1;
                        cnt_d    = cnt_q + TW'(1);
                    end
                end
            end
            S_DECODE: begin
                if (!op_legal || (is_r && funct_bad)) begin
                    fault_d = 1'b1;
                    state_d = S_HALT;
                end else if (is_j) begin
                    c_sel_jump = 1'b1;
                    c_pc_en    = 1'b1;
                    state_d    = S_FETCH;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                c_alu_ctrl  = dec_alu;
                c_sel_alu_b = !(is_r || is_beq);
                if (is_beq) begin
                    c_sel_pc = zero;
                    c_pc_en  = 1'b1;
                    state_d  = S_FETCH;
                end else if (is_lw || is_sw) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                c_dmem_req  = 1'b1;
                c_dmem_we   = is_sw;
                c_alu_ctrl  = ALU_ADD;
                c_sel_alu_b = 1'b1;
                if (mem.dmem_ack) begin
                    c_we         = is_lw;
                    c_sel_result = is_lw;
                    c_pc_en      = 1'b1;
                    state_d      = S_FETCH;
                end else if (timed_out) begin
                    fault_d = 1'b1;
                    state_d = S_HALT;
                end else begin
                    cnt_d = cnt_q + TW'(1);
                end
            end
            S_WB: begin
                c_we        = 1'b1;
                c_sel_wa    = is_r;
                c_alu_ctrl  = dec_alu;
                c_sel_alu_b = !is_r;
                c_pc_en     = 1'b1;
                state_d     = S_FETCH;
            end
            S_HALT: ;
            default: begin
                fault_d = 1'b1;
                state_d = S_HALT;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= S_FETCH;
            instr_q  <= '0;
            cnt_q    <= '0;
            fault_q  <= 1'b0;
            issued_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            instr_q  <= instr_d;
            cnt_q    <= cnt_d;
            fault_q  <= fault_d;
            issued_q <= issued_d;
        end
    end

    // Gating with reset drops requests the instant reset falls, without waiting for a clock.
    assign mem.imem_req = reset & c_imem_req;
    assign mem.dmem_req = reset & c_dmem_req;
    assign mem.dmem_we  = reset & c_dmem_we;
    assign sel_result   = reset & c_sel_result;
    assign sel_pc       = reset & c_sel_pc;
    assign sel_alu_b    = reset & c_sel_alu_b;
    assign sel_wa       = reset & c_sel_wa;
    assign we           = reset & c_we;
    assign sel_jump     = reset & c_sel_jump;
    assign alu_ctrl     = {3{reset}} & c_alu_ctrl;
    assign pc_en        = reset & c_pc_en;
    assign retire       = reset & c_pc_en;
    assign fault        = reset & fault_q;
    assign state        = {3{reset}} & state_q;
    assign instruction  = {32{reset}} & instr_q;

endmodule
